// File: rtl/channel_dump_ctrl.sv
// Channel dump sequencer: reads DEPTH samples of one capture channel, oldest first,
// and hands each byte to the UART transmitter over a trmt/tx_done handshake.
//
//  state  | meaning
//  IDLE   | waiting for a dump command
//  RD     | RAM read enable asserted for the current address
//  LAT    | waiting out the RAM read latency, captures the sample on the last cycle
//  SEND   | transmit strobe high
//  TXW    | waiting for the transmitter to finish the byte
//  FIN    | dump_fin pulse (completed, aborted or rejected)
module channel_dump_ctrl #(
    parameter int AW     = 9,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          dump_i,
    input  logic [1:0]    ch_sel_i,
    input  logic [AW-1:0] start_addr_i,
    input  logic          abort_i,
    output logic          ram_en_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [1:0]    ram_ch_o,
    input  logic [DW-1:0] ram_rdata_i,
    output logic [DW-1:0] tx_data_o,
    output logic          trmt_o,
    input  logic          tx_done_i,
    output logic          busy_o,
    output logic          dump_fin_o,
    output logic          dump_err_o
);

    localparam int         DEPTH    = 2 ** AW;
    localparam logic [AW:0] LAST    = (AW + 1)'(DEPTH - 1);
    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_LAT,
        S_SEND,
        S_TXW,
        S_FIN
    } state_t;

    state_t        state_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   byte_cnt_q;
    logic [1:0]    lat_cnt_q;
    logic [DW-1:0] tx_data_q;
    logic [1:0]    ram_ch_q;
    logic          ram_en_q;
    logic          trmt_q;
    logic          fin_q;
    logic          err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            byte_cnt_q <= '0;
            lat_cnt_q  <= '0;
            tx_data_q  <= '0;
            ram_ch_q   <= '0;
            ram_en_q   <= 1'b0;
            trmt_q     <= 1'b0;
            fin_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ram_en_q <= 1'b0;
            trmt_q   <= 1'b0;
            fin_q    <= 1'b0;
            err_q    <= 1'b0;
            // abort wins over everything, including a coincident tx_done
            if (abort_i && state_q != S_IDLE && state_q != S_FIN) begin
                state_q <= S_FIN;
                fin_q   <= 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (dump_i) begin
                            if (ch_sel_i == 2'd3) begin
                                state_q <= S_FIN;
                                fin_q   <= 1'b1;
                                err_q   <= 1'b1;
                            end else begin
                                state_q    <= S_RD;
                                ram_ch_q   <= ch_sel_i;
                                rd_ptr_q   <= start_addr_i;
                                byte_cnt_q <= '0;
                                ram_en_q   <= 1'b1;
                            end
                        end
                    end
                    S_RD: begin
                        state_q   <= S_LAT;
                        lat_cnt_q <= LAT_LOAD;
                    end
                    S_LAT: begin
                        if (lat_cnt_q == 2'd0) begin
                            tx_data_q <= ram_rdata_i;
                            trmt_q    <= 1'b1;
                            state_q   <= S_SEND;
                        end else begin
                            lat_cnt_q <= lat_cnt_q - 2'd1;
                        end
                    end
                    S_SEND: state_q <= S_TXW;
                    S_TXW: begin
                        if (tx_done_i) begin
                            if (byte_cnt_q == LAST) begin
                                state_q <= S_FIN;
                                fin_q   <= 1'b1;
                            end else begin
                                state_q    <= S_RD;
                                rd_ptr_q   <= rd_ptr_q + 1'b1;
                                byte_cnt_q <= byte_cnt_q + 1'b1;
                                ram_en_q   <= 1'b1;
                            end
                        end
                    end
                    S_FIN:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ram_en_o   = ram_en_q;
    assign ram_addr_o = rd_ptr_q;
    assign ram_ch_o   = ram_ch_q;
    assign tx_data_o  = tx_data_q;
    assign trmt_o     = trmt_q;
    assign busy_o     = (state_q != S_IDLE);
    assign dump_fin_o = fin_q;
    assign dump_err_o = err_q;

endmodule

// File: tb/tb_channel_dump_ctrl.sv
// Directed bench for channel_dump_ctrl with a 2-cycle RAM model and a UART model
// that answers each trmt with tx_done 10 cycles later.
module tb_channel_dump_ctrl;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          dump = 1'b0;
    logic [1:0]    ch_sel = '0;
    logic [AW-1:0] start_addr = '0;
    logic          abort;
    logic          ram_en;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_ch;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] tx_data;
    logic          trmt;
    logic          tx_done;
    logic          busy;
    logic          dump_fin;
    logic          dump_err;

    logic abort_tx, abort_ini = 1'b0;
    logic tx_done_m, tx_done_ini = 1'b0;
    assign abort   = abort_tx | abort_ini;
    assign tx_done = tx_done_m | tx_done_ini;

    channel_dump_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dump_i       (dump),
        .ch_sel_i     (ch_sel),
        .start_addr_i (start_addr),
        .abort_i      (abort),
        .ram_en_o     (ram_en),
        .ram_addr_o   (ram_addr),
        .ram_ch_o     (ram_ch),
        .ram_rdata_i  (ram_rdata),
        .tx_data_o    (tx_data),
        .trmt_o       (trmt),
        .tx_done_i    (tx_done),
        .busy_o       (busy),
        .dump_fin_o   (dump_fin),
        .dump_err_o   (dump_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: data = addr ^ A5, valid only in the exact cycle RL after ram_en
    logic [DW-1:0] p1 = '0;
    always @(posedge clk) begin
        p1        <= ram_en ? (ram_addr[7:0] ^ 8'hA5) : ~p1;
        ram_rdata <= p1;
    end

    int abort_at = -1;
    int trmt_cnt = 0, ramen_cnt = 0, fin_cnt = 0, err_cnt = 0;
    int order_err = 0, data_err = 0, lat_err = 0, errnofin = 0;
    int last_evt = -100, abort_cyc = -100, fin_cyc = -100;
    logic          in_txw = 1'b0;
    logic [AW-1:0] exp_addr = '0, exp_tx_addr = '0;
    logic [1:0]    exp_ch = '0;

    initial begin
        tx_done_m = 1'b0;
        abort_tx  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && trmt) begin
                repeat (10) @(posedge clk);
                #1;
                tx_done_m = 1'b1;
                abort_tx  = (trmt_cnt == abort_at);
                @(posedge clk);
                #1;
                tx_done_m = 1'b0;
                abort_tx  = 1'b0;
            end
        end
    end

    // reference model of address order, data and cycle latencies
    always @(negedge clk) begin
        if (!rst_n) begin
            in_txw = 1'b0;
        end else begin
            if (dump && !busy) begin
                last_evt = cyc;
                if (ch_sel != 2'd3) begin
                    exp_addr    = start_addr;
                    exp_tx_addr = start_addr;
                    exp_ch      = ch_sel;
                end
            end
            if (ram_en) begin
                if (ram_addr !== exp_addr || ram_ch !== exp_ch) order_err++;
                if (cyc != last_evt + 1) lat_err++;
                exp_addr = exp_addr + 9'd1;
                ramen_cnt++;
            end
            if (tx_done && in_txw) begin
                last_evt = cyc;
                in_txw   = 1'b0;
            end
            if (trmt) begin
                if (tx_data !== (exp_tx_addr[7:0] ^ 8'hA5)) data_err++;
                if (cyc != last_evt + 2 + RL) lat_err++;
                exp_tx_addr = exp_tx_addr + 9'd1;
                in_txw = 1'b1;
                trmt_cnt++;
            end
            if (abort && busy) abort_cyc = cyc;
            if (dump_fin) begin
                fin_cnt++;
                fin_cyc = cyc;
            end
            if (dump_err) err_cnt++;
            if (dump_err && !dump_fin) errnofin++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_dump(input logic [1:0] ch, input logic [AW-1:0] addr);
        @(posedge clk); #1;
        ch_sel = ch; start_addr = addr; dump = 1'b1;
        @(posedge clk); #1;
        dump = 1'b0; ch_sel = 2'd3; start_addr = ~addr;
    endtask

    task automatic wait_fin(input string tag, input int base);
        int n = 0;
        while (fin_cnt == base && n < 12000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(fin_cnt - base), 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int target);
        int n = 0;
        while (trmt_cnt < target && n < 12000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(trmt_cnt >= target), 32'd1);
    endtask

    int b_t, b_r, b_f, b_e;

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", {ram_en, ram_addr, ram_ch, tx_data, trmt, busy, dump_fin, dump_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: full dump from 0 on channel 1
        b_t = trmt_cnt; b_r = ramen_cnt; b_f = fin_cnt; b_e = err_cnt;
        start_dump(2'd1, 9'h000);
        chk("t1_busy", busy, 1'b1);
        wait_fin("t1_fin", b_f);
        chk("t1_trmt", 32'(trmt_cnt - b_t), 32'd512);
        chk("t1_ramen", 32'(ramen_cnt - b_r), 32'd512);
        chk("t1_err", 32'(err_cnt - b_e), 32'd0);
        chk("t1_ram_ch", ram_ch, 2'd1);
        @(posedge clk); #1;
        chk("t1_idle", busy, 1'b0);
        chk("t1_order", 32'(order_err), 32'd0);
        chk("t1_data", 32'(data_err), 32'd0);
        chk("t1_lat", 32'(lat_err), 32'd0);

        // 5: rejected channel 3
        b_r = ramen_cnt; b_t = trmt_cnt;
        @(posedge clk); #1;
        ch_sel = 2'd3; dump = 1'b1;
        @(posedge clk); #1;
        dump = 1'b0;
        chk("t5_fin", dump_fin, 1'b1);
        chk("t5_err", dump_err, 1'b1);
        chk("t5_ramen", ram_en, 1'b0);
        @(posedge clk); #1;
        chk("t5_fin_pulse", {dump_fin, dump_err, busy}, 3'b000);
        chk("t5_no_read", 32'((ramen_cnt - b_r) + (trmt_cnt - b_t)), 32'd0);
        chk("t5_errnofin", 32'(errnofin), 32'd0);

        // 2: wrapped start, with a dump while busy and a stray tx_done
        b_t = trmt_cnt; b_r = ramen_cnt; b_f = fin_cnt;
        start_dump(2'd2, 9'h1F0);
        wait_bytes("t2_first5", b_t + 5);
        ch_sel = 2'd0; start_addr = 9'h055; dump = 1'b1;
        @(posedge clk); #1;
        dump = 1'b0;
        begin
            int n = 0;
            while (!trmt && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            chk("t2_send_seen", trmt, 1'b1);
        end
        tx_done_ini = 1'b1;
        @(posedge clk); #1;
        tx_done_ini = 1'b0;
        wait_fin("t2_fin", b_f);
        chk("t2_trmt", 32'(trmt_cnt - b_t), 32'd512);
        chk("t2_ramen", 32'(ramen_cnt - b_r), 32'd512);
        chk("t2_ram_ch", ram_ch, 2'd2);
        chk("t2_order", 32'(order_err), 32'd0);
        chk("t3_data", 32'(data_err), 32'd0);
        chk("t3_lat", 32'(lat_err), 32'd0);

        // 4: abort with tx_done after byte 37, then restart
        b_t = trmt_cnt; b_f = fin_cnt;
        abort_at = trmt_cnt + 37;
        start_dump(2'd0, 9'h0A0);
        wait_fin("t4_fin", b_f);
        abort_at = -1;
        chk("t4_trmt", 32'(trmt_cnt - b_t), 32'd37);
        chk("t4_fin_lat", 32'(fin_cyc - abort_cyc), 32'd1);
        @(posedge clk); #1;
        chk("t4_idle", busy, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("t4_quiet", 32'(trmt_cnt - b_t), 32'd37);
        b_t = trmt_cnt; b_f = fin_cnt;
        start_dump(2'd1, 9'h123);
        wait_fin("t4_re_fin", b_f);
        chk("t4_re_trmt", 32'(trmt_cnt - b_t), 32'd512);
        chk("t4_order", 32'(order_err), 32'd0);

        // 6: reset during byte 100, then fresh dump (abort in IDLE ignored)
        b_t = trmt_cnt; b_f = fin_cnt;
        start_dump(2'd1, 9'h000);
        wait_bytes("t6_100", b_t + 100);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_outs", {ram_en, ram_addr, ram_ch, tx_data, trmt, busy, dump_fin, dump_err}, 32'd0);
        repeat (15) @(negedge clk);
        rst_n = 1'b1;
        chk("t6_no_fin", 32'(fin_cnt - b_f), 32'd0);
        b_t = trmt_cnt; b_f = fin_cnt;
        @(posedge clk); #1;
        abort_ini = 1'b1; ch_sel = 2'd1; start_addr = 9'h000; dump = 1'b1;
        @(posedge clk); #1;
        abort_ini = 1'b0; dump = 1'b0;
        chk("t6_accept", busy, 1'b1);
        wait_fin("t6_fin", b_f);
        chk("t6_trmt", 32'(trmt_cnt - b_t), 32'd512);
        chk("t6_order", 32'(order_err + data_err + lat_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
